cam_match_resolver: RTL and testbench

Downstream stage of the CAM array wrapper. It consumes the one-hot/multi-hot decoded match vector and serialises it into binary match addresses, lowest index first, one per handshake beat. It also reports no-match, multi-match and the popcount of each vector. It sits between the CAM wrapper output and the lookup/response logic.

---
 rtl/cam_match_resolver.sv | 133 +++++++++++++
 tb/tb_cam_match_resolver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_match_resolver.sv
// cam_match_resolver
//   Takes decoded (one-hot / multi-hot) match vectors from the CAM wrapper
//   and turns each one into a stream of binary row addresses. The lowest
//   index comes out first, and one address is sent per valid/ready beat.
//   For every accepted vector the block also reports:
//     - the popcount of the vector,
//     - whether two or more rows matched,
//     - a one-cycle no-match pulse when no row matched.
//
// Ports
//   clk                    system clock, rising edge
//   rst                    asynchronous reset, active low
//   match_valid            decoded_match_address is valid this cycle
//   decoded_match_address  match vector, bit i = row i matched
//   match_ready            resolver can accept a vector (idle, no flush)
//   flush                  synchronous abort of the vector in flight
//   match_addr             index of the lowest pending matched row
//   match_addr_valid       match_addr is valid
//   match_addr_ready       consumer takes match_addr
//   match_last             current beat is the final address of the vector
//   no_match               one-cycle pulse: accepted vector was all zeros
//   multi_match            last accepted vector had >= 2 bits set (held)
//   match_count            popcount of last accepted vector (held)
module cam_match_resolver #(
   parameter int CAM_DEPTH  = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  match_valid,
   input  logic [CAM_DEPTH-1:0]  decoded_match_address,
   output logic                  match_ready,
   input  logic                  flush,
   output logic [ADDR_WIDTH-1:0] match_addr,
   output logic                  match_addr_valid,
   input  logic                  match_addr_ready,
   output logic                  match_last,
   output logic                  no_match,
   output logic                  multi_match,
   output logic [ADDR_WIDTH:0]   match_count
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t                state_reg;
   logic [CAM_DEPTH-1:0]  pending_reg;
   logic                  no_match_reg;
   logic                  multi_match_reg;
   logic [ADDR_WIDTH:0]   match_count_reg;

   logic [CAM_DEPTH-1:0]  lowest_onehot;
   logic [CAM_DEPTH-1:0]  pending_rest;
   logic [ADDR_WIDTH-1:0] lowest_addr;
   logic                  pending_last;
   logic [ADDR_WIDTH:0]   vec_count;
   logic                  accept;
   logic                  beat;

   // Isolate the lowest set bit. pending & (pending - 1) is the same
   // vector with that bit removed, which is exactly the vector left
   // after the beat.
   assign lowest_onehot = pending_reg & (~pending_reg + CAM_DEPTH'(1));
   assign pending_rest  = pending_reg & (pending_reg - CAM_DEPTH'(1));
   assign pending_last  = (pending_reg != '0) && (pending_rest == '0);

   // Encode the isolated one-hot bit into a binary row index.
   always_comb begin
      lowest_addr = '0;
      for (int i = 0; i < CAM_DEPTH; i++) begin
         if (lowest_onehot[i]) begin
            lowest_addr = lowest_addr | ADDR_WIDTH'(i);
         end
      end
   end

   // Popcount of the incoming vector. It is only captured when a vector
   // is accepted.
   always_comb begin
      vec_count = '0;
      for (int i = 0; i < CAM_DEPTH; i++) begin
         vec_count = vec_count + {{ADDR_WIDTH{1'b0}}, decoded_match_address[i]};
      end
   end

   assign match_ready = (state_reg == IDLE) && !flush;
   assign accept      = match_valid && match_ready;
   assign beat        = (state_reg == EMIT) && match_addr_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         pending_reg     <= '0;
         no_match_reg    <= 1'b0;
         multi_match_reg <= 1'b0;
         match_count_reg <= '0;
      end else begin
         no_match_reg <= 1'b0;
         if (flush) begin
            // A beat on the same edge is treated as consumed. Nothing
            // else from this vector is sent. Statistics are kept.
            pending_reg <= '0;
            state_reg   <= IDLE;
         end else if (accept) begin
            pending_reg     <= decoded_match_address;
            match_count_reg <= vec_count;
            multi_match_reg <= (vec_count >= (ADDR_WIDTH + 1)'(2));
            if (decoded_match_address != '0) begin
               state_reg <= EMIT;
            end else begin
               no_match_reg <= 1'b1;
            end
         end else if (beat) begin
            pending_reg <= pending_rest;
            if (pending_last) begin
               state_reg <= IDLE;
            end
         end
      end
   end

   // The address outputs depend only on state and pending. They have no
   // combinational path from any input, so they hold under backpressure.
   assign match_addr_valid = (state_reg == EMIT);
   assign match_addr       = lowest_addr;
   assign match_last       = (state_reg == EMIT) && pending_last;
   assign no_match         = no_match_reg;
   assign multi_match      = multi_match_reg;
   assign match_count      = match_count_reg;

endmodule

// File: tb/tb_cam_match_resolver.sv
module tb_cam_match_resolver;

   logic       clk;
   logic       rst;
   logic       match_valid;
   logic [7:0] decoded_match_address;
   logic       match_ready;
   logic       flush;
   logic [2:0] match_addr;
   logic       match_addr_valid;
   logic       match_addr_ready;
   logic       match_last;
   logic       no_match;
   logic       multi_match;
   logic [3:0] match_count;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: the rows still to be reported, as a queue of indices
   // in ascending order, plus the statistics of the last accepted vector.
   int   q[$];
   int   beats[$];
   logic exp_nm;
   logic exp_mm;
   int   exp_cnt;

   cam_match_resolver #(.CAM_DEPTH(8), .ADDR_WIDTH(3)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .match_valid           (match_valid),
      .decoded_match_address (decoded_match_address),
      .match_ready           (match_ready),
      .flush                 (flush),
      .match_addr            (match_addr),
      .match_addr_valid      (match_addr_valid),
      .match_addr_ready      (match_addr_ready),
      .match_last            (match_last),
      .no_match              (no_match),
      .multi_match           (multi_match),
      .match_count           (match_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      exp_nm  = 1'b0;
      exp_mm  = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, match_addr_valid, 1'b0);
      chk({tag, "_addr"},  match_addr, 3'd0);
      chk({tag, "_last"},  match_last, 1'b0);
      chk({tag, "_nm"},    no_match, 1'b0);
      chk({tag, "_mm"},    multi_match, 1'b0);
      chk({tag, "_cnt"},   match_count, 4'd0);
      chk({tag, "_ready"}, match_ready, 1'b1);
   endtask

   task automatic check_outputs();
      chk("valid", match_addr_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("addr", match_addr, q[0]);
         chk("last", match_last, q.size() == 1);
      end
      chk("no_match", no_match, exp_nm);
      chk("multi", multi_match, exp_mm);
      chk("count", match_count, exp_cnt);
   endtask

   // One clock cycle. The task is entered on a falling edge. It checks the
   // outputs, drives the inputs, advances the model to the state after the
   // next rising edge, and returns on the following falling edge.
   task automatic cycle(input logic mv, input logic [7:0] vec, input logic ar, input logic fl);
      check_outputs();
      match_valid           = mv;
      decoded_match_address = vec;
      match_addr_ready      = ar;
      flush                 = fl;
      #1;
      chk("ready", match_ready, (q.size() == 0) && !fl);
      if (match_addr_valid && ar) beats.push_back(int'(match_addr));
      exp_nm = 1'b0;
      if (fl) begin
         q.delete();
      end else if (q.size() > 0) begin
         if (ar) void'(q.pop_front());
      end else if (mv) begin
         for (int i = 0; i < 8; i++) if (vec[i]) q.push_back(i);
         exp_cnt = q.size();
         exp_mm  = (q.size() >= 2);
         exp_nm  = (vec == 8'h00);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      match_valid = 1'b0;
      decoded_match_address = 8'h00;
      match_addr_ready = 1'b0;
      flush = 1'b0;
      model_clear();

      // 1. reset held for 3 cycles with random inputs
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         match_valid           = 1'($urandom);
         decoded_match_address = 8'($urandom);
         match_addr_ready      = 1'($urandom);
         #1;
         check_reset_outputs("rst");
         @(negedge clk);
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // 2. zero vector
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // 3. single hit on row 5
      beats.delete();
      cycle(1'b1, 8'h20, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t3_nbeats", beats.size(), 1);
      if (beats.size() == 1) chk("t3_addr", beats[0], 5);

      // 4. multi hit, with match_valid offered during EMIT
      beats.delete();
      cycle(1'b1, 8'h89, 1'b1, 1'b0);
      cycle(1'b1, 8'h40, 1'b1, 1'b0);
      cycle(1'b1, 8'h40, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t4_nbeats", beats.size(), 3);
      if (beats.size() == 3) begin
         chk("t4_b0", beats[0], 0);
         chk("t4_b1", beats[1], 3);
         chk("t4_b2", beats[2], 7);
      end

      // 5. all-ones vector with backpressure
      beats.delete();
      cycle(1'b1, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t5_nbeats", beats.size(), 8);
      chk("t5_count", match_count, 4'd8);
      for (int i = 0; i < 8 && i < beats.size(); i++) chk("t5_seq", beats[i], i);

      // 6a. flush on the beat for address 1
      beats.delete();
      cycle(1'b1, 8'h0F, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t6_nbeats", beats.size(), 2);

      // 6b. asynchronous reset during EMIT
      cycle(1'b1, 8'h0F, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check_outputs();
      match_addr_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("arst");
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [7:0] v;
         v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
         cycle($urandom_range(0, 2) != 0, v, $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0);
      end
      check_outputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
